alu_issue_stage: RTL and testbench

ID/EX issue stage for the pipelined RV32I core: the producer side of the ALU operand interface. It registers one decoded instruction per cycle. It resolves RAW hazards by forwarding from MEM and WB and inserts a one-cycle bubble on load-use. It holds its contents on downstream stall and kills them on flush. It drives the ALU's operand, select, op and `br_less` inputs directly.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/fwd_mux.sv | 31 +++
 rtl/alu_issue_stage.sv | 211 +++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the RV32I execute path: op codes, issue FSM
// states and the datapath width.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SRA  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_XOR  = 4'b1010,
    ALU_SRL  = 4'b1011,
    ALU_LUI  = 4'b1100
  } alu_op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } issue_state_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: x0 reads as zero, the younger MEM result beats the
// older WB result, otherwise the value captured at issue is used.
module fwd_mux
  import alu_pkg::*;
(
  input  logic [4:0]      rs_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [4:0]      mem_rd_addr,
  input  logic            mem_rd_wren,
  input  logic [XLEN-1:0] mem_data,
  input  logic [4:0]      wb_rd_addr,
  input  logic            wb_rd_wren,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fwd_data
);

  // Select the most recent producer of rs_addr.
  always_comb begin
    fwd_data = rs_data;
    if (rs_addr == 5'd0) begin
      fwd_data = {XLEN{1'b0}};
    end else if (mem_rd_wren && (mem_rd_addr == rs_addr)) begin
      fwd_data = mem_data;
    end else if (wb_rd_wren && (wb_rd_addr == rs_addr)) begin
      fwd_data = wb_data;
    end else begin
      fwd_data = rs_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: registers one decoded instruction per cycle, forwards
// operands from MEM/WB, inserts one bubble on load-use, holds on stall and
// kills on flush. Drives the ALU operand/select/op and br_less inputs.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_id_valid,
  output logic            o_id_ready,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [XLEN-1:0] i_id_imm,
  input  logic [XLEN-1:0] i_id_rs1_data,
  input  logic [XLEN-1:0] i_id_rs2_data,
  input  logic [4:0]      i_id_rs1_addr,
  input  logic [4:0]      i_id_rs2_addr,
  input  logic [4:0]      i_id_rd_addr,
  input  logic            i_id_op_a_sel,
  input  logic            i_id_op_b_sel,
  input  logic [3:0]      i_id_alu_op,
  input  logic            i_id_br_unsigned,
  input  logic            i_id_rd_wren,
  input  logic            i_id_is_load,
  input  logic            i_flush,
  input  logic            i_ex_stall,
  input  logic [4:0]      i_mem_rd_addr,
  input  logic            i_mem_rd_wren,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic [4:0]      i_wb_rd_addr,
  input  logic            i_wb_rd_wren,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [XLEN-1:0] o_operand_a,
  output logic [XLEN-1:0] o_operand_b,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_imm,
  output logic            o_op_a_sel,
  output logic            o_op_b_sel,
  output logic [3:0]      o_alu_op,
  output logic            o_br_less,
  output logic            o_ex_valid,
  output logic [4:0]      o_ex_rd_addr,
  output logic            o_ex_rd_wren,
  output logic            o_ex_is_load
);

  issue_state_e    state_q, state_d;
  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [4:0]      rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic            op_a_sel_q, op_a_sel_d, op_b_sel_q, op_b_sel_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            br_unsigned_q, br_unsigned_d;
  logic            rd_wren_q, rd_wren_d, is_load_q, is_load_d;

  logic [XLEN-1:0] fwd_a_s, fwd_b_s, cmp_a_s, cmp_b_s;
  logic [XLEN:0]   cmp_diff_s;
  logic            load_use_s;

  fwd_mux u_fwd_a (
    .rs_addr     (rs1_addr_q),
    .rs_data     (rs1_data_q),
    .mem_rd_addr (i_mem_rd_addr),
    .mem_rd_wren (i_mem_rd_wren),
    .mem_data    (i_mem_data),
    .wb_rd_addr  (i_wb_rd_addr),
    .wb_rd_wren  (i_wb_rd_wren),
    .wb_data     (i_wb_data),
    .fwd_data    (fwd_a_s)
  );

  fwd_mux u_fwd_b (
    .rs_addr     (rs2_addr_q),
    .rs_data     (rs2_data_q),
    .mem_rd_addr (i_mem_rd_addr),
    .mem_rd_wren (i_mem_rd_wren),
    .mem_data    (i_mem_data),
    .wb_rd_addr  (i_wb_rd_addr),
    .wb_rd_wren  (i_wb_rd_wren),
    .wb_data     (i_wb_data),
    .fwd_data    (fwd_b_s)
  );

  // A live load in EX whose rd is read by the instruction waiting in ID.
  assign load_use_s = ex_valid_q && is_load_q && rd_wren_q && (rd_addr_q != 5'd0) &&
                      i_id_valid &&
                      ((rd_addr_q == i_id_rs1_addr) || (rd_addr_q == i_id_rs2_addr));

  assign o_id_ready = !i_rst && !i_ex_stall && !load_use_s;

  // Next EX contents and FSM state: flush > stall > load-use > normal issue.
  always_comb begin
    state_d       = state_q;
    ex_valid_d    = ex_valid_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    rs1_data_d    = rs1_data_q;
    rs2_data_d    = rs2_data_q;
    rs1_addr_d    = rs1_addr_q;
    rs2_addr_d    = rs2_addr_q;
    rd_addr_d     = rd_addr_q;
    op_a_sel_d    = op_a_sel_q;
    op_b_sel_d    = op_b_sel_q;
    alu_op_d      = alu_op_q;
    br_unsigned_d = br_unsigned_q;
    rd_wren_d     = rd_wren_q;
    is_load_d     = is_load_q;
    if (i_flush) begin
      state_d    = ST_RUN;
      ex_valid_d = 1'b0;
      rd_wren_d  = 1'b0;
      is_load_d  = 1'b0;
    end else if (i_ex_stall) begin
      // Keep absorbing results that retire while we wait.
      rs1_data_d = fwd_a_s;
      rs2_data_d = fwd_b_s;
    end else if (load_use_s) begin
      state_d    = ST_BUBBLE;
      ex_valid_d = 1'b0;
      rd_wren_d  = 1'b0;
      is_load_d  = 1'b0;
    end else begin
      // BUBBLE always returns to RUN; ID is accepted the same way in both.
      state_d = ST_RUN;
      if (i_id_valid) begin
        ex_valid_d    = 1'b1;
        pc_d          = i_id_pc;
        imm_d         = i_id_imm;
        rs1_data_d    = i_id_rs1_data;
        rs2_data_d    = i_id_rs2_data;
        rs1_addr_d    = i_id_rs1_addr;
        rs2_addr_d    = i_id_rs2_addr;
        rd_addr_d     = i_id_rd_addr;
        op_a_sel_d    = i_id_op_a_sel;
        op_b_sel_d    = i_id_op_b_sel;
        alu_op_d      = i_id_alu_op;
        br_unsigned_d = i_id_br_unsigned;
        rd_wren_d     = i_id_rd_wren;
        is_load_d     = i_id_is_load;
      end else begin
        ex_valid_d = 1'b0;
        rd_wren_d  = 1'b0;
        is_load_d  = 1'b0;
      end
    end
  end

  // EX pipeline register and FSM state, cleared immediately by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_RUN;
      ex_valid_q    <= 1'b0;
      pc_q          <= {XLEN{1'b0}};
      imm_q         <= {XLEN{1'b0}};
      rs1_data_q    <= {XLEN{1'b0}};
      rs2_data_q    <= {XLEN{1'b0}};
      rs1_addr_q    <= 5'd0;
      rs2_addr_q    <= 5'd0;
      rd_addr_q     <= 5'd0;
      op_a_sel_q    <= 1'b0;
      op_b_sel_q    <= 1'b0;
      alu_op_q      <= ALU_ADD;
      br_unsigned_q <= 1'b0;
      rd_wren_q     <= 1'b0;
      is_load_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ex_valid_q    <= ex_valid_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rd_addr_q     <= rd_addr_d;
      op_a_sel_q    <= op_a_sel_d;
      op_b_sel_q    <= op_b_sel_d;
      alu_op_q      <= alu_op_d;
      br_unsigned_q <= br_unsigned_d;
      rd_wren_q     <= rd_wren_d;
      is_load_q     <= is_load_d;
    end
  end

  // Less-than on the selected ALU inputs: extend by sign (or zero) to 33
  // bits and take the borrow/sign of the difference.
  always_comb begin
    cmp_a_s = op_a_sel_q ? pc_q : fwd_a_s;
    cmp_b_s = op_b_sel_q ? imm_q : fwd_b_s;
    if (br_unsigned_q) begin
      cmp_diff_s = {1'b0, cmp_a_s} - {1'b0, cmp_b_s};
    end else begin
      cmp_diff_s = {cmp_a_s[XLEN-1], cmp_a_s} - {cmp_b_s[XLEN-1], cmp_b_s};
    end
  end

  assign o_br_less    = cmp_diff_s[XLEN];
  assign o_operand_a  = fwd_a_s;
  assign o_operand_b  = fwd_b_s;
  assign o_pc         = pc_q;
  assign o_imm        = imm_q;
  assign o_op_a_sel   = op_a_sel_q;
  assign o_op_b_sel   = op_b_sel_q;
  assign o_alu_op     = alu_op_q;
  assign o_ex_valid   = ex_valid_q;
  assign o_ex_rd_addr = rd_addr_q;
  assign o_ex_rd_wren = rd_wren_q;
  assign o_ex_is_load = is_load_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural EX-slot model checked
// every falling edge, plus hand-computed literal checks.
module tb_alu_issue_stage;

  logic        clk, rst;
  logic        id_valid, id_asel, id_bsel, id_uns, id_wren, id_load;
  logic [31:0] id_pc, id_imm, id_rs1d, id_rs2d;
  logic [4:0]  id_rs1a, id_rs2a, id_rd;
  logic [3:0]  id_op;
  logic        flush, stall;
  logic [4:0]  mem_a, wb_a;
  logic        mem_w, wb_w;
  logic [31:0] mem_d, wb_d;

  logic        o_id_ready, o_op_a_sel, o_op_b_sel, o_br_less;
  logic        o_ex_valid, o_ex_rd_wren, o_ex_is_load;
  logic [31:0] o_operand_a, o_operand_b, o_pc, o_imm;
  logic [3:0]  o_alu_op;
  logic [4:0]  o_ex_rd_addr;

  int tests = 0;
  int fails = 0;
  logic cmp_on = 1'b0;

  // Model of the EX slot contents.
  logic        m_valid, m_asel, m_bsel, m_uns, m_wren, m_load;
  logic [31:0] m_pc, m_imm, m_rs1d, m_rs2d;
  logic [4:0]  m_rs1a, m_rs2a, m_rd;
  logic [3:0]  m_op;

  alu_issue_stage dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .o_id_ready(o_id_ready),
    .i_id_pc(id_pc), .i_id_imm(id_imm), .i_id_rs1_data(id_rs1d), .i_id_rs2_data(id_rs2d),
    .i_id_rs1_addr(id_rs1a), .i_id_rs2_addr(id_rs2a), .i_id_rd_addr(id_rd),
    .i_id_op_a_sel(id_asel), .i_id_op_b_sel(id_bsel), .i_id_alu_op(id_op),
    .i_id_br_unsigned(id_uns), .i_id_rd_wren(id_wren), .i_id_is_load(id_load),
    .i_flush(flush), .i_ex_stall(stall),
    .i_mem_rd_addr(mem_a), .i_mem_rd_wren(mem_w), .i_mem_data(mem_d),
    .i_wb_rd_addr(wb_a), .i_wb_rd_wren(wb_w), .i_wb_data(wb_d),
    .o_operand_a(o_operand_a), .o_operand_b(o_operand_b), .o_pc(o_pc), .o_imm(o_imm),
    .o_op_a_sel(o_op_a_sel), .o_op_b_sel(o_op_b_sel), .o_alu_op(o_alu_op),
    .o_br_less(o_br_less), .o_ex_valid(o_ex_valid), .o_ex_rd_addr(o_ex_rd_addr),
    .o_ex_rd_wren(o_ex_rd_wren), .o_ex_is_load(o_ex_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest producer wins; x0 is always zero.
  function automatic logic [31:0] mfwd(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return 32'd0;
    if (mem_w && mem_a == a) return mem_d;
    if (wb_w && wb_a == a) return wb_d;
    return d;
  endfunction

  function automatic logic m_lu();
    return m_valid && m_load && m_wren && (m_rd != 5'd0) && id_valid &&
           ((m_rd == id_rs1a) || (m_rd == id_rs2a));
  endfunction

  // Model update at each edge, in the order reset, flush, stall, load-use, issue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_pc <= 32'd0; m_imm <= 32'd0; m_rs1d <= 32'd0; m_rs2d <= 32'd0;
      m_rs1a <= 5'd0; m_rs2a <= 5'd0; m_rd <= 5'd0; m_asel <= 1'b0; m_bsel <= 1'b0;
      m_op <= 4'd0; m_uns <= 1'b0; m_wren <= 1'b0; m_load <= 1'b0;
    end else if (flush || (!stall && (m_lu() || !id_valid))) begin
      m_valid <= 1'b0; m_wren <= 1'b0; m_load <= 1'b0;
    end else if (stall) begin
      m_rs1d <= mfwd(m_rs1a, m_rs1d);
      m_rs2d <= mfwd(m_rs2a, m_rs2d);
    end else begin
      m_valid <= 1'b1; m_pc <= id_pc; m_imm <= id_imm; m_rs1d <= id_rs1d; m_rs2d <= id_rs2d;
      m_rs1a <= id_rs1a; m_rs2a <= id_rs2a; m_rd <= id_rd; m_asel <= id_asel;
      m_bsel <= id_bsel; m_op <= id_op; m_uns <= id_uns; m_wren <= id_wren; m_load <= id_load;
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic [31:0] ea, eb, ca, cb;
    logic        el;
    if (cmp_on) begin
      ea = mfwd(m_rs1a, m_rs1d);
      eb = mfwd(m_rs2a, m_rs2d);
      ca = m_asel ? m_pc : ea;
      cb = m_bsel ? m_imm : eb;
      el = m_uns ? (ca < cb) : ($signed(ca) < $signed(cb));
      chk("m_ready", 32'(o_id_ready), 32'(!rst && !stall && !m_lu()));
      chk("m_ex_valid", 32'(o_ex_valid), 32'(m_valid));
      chk("m_rd_wren", 32'(o_ex_rd_wren), 32'(m_wren));
      if (m_valid || rst) begin
        chk("m_operand_a", o_operand_a, ea);
        chk("m_operand_b", o_operand_b, eb);
        chk("m_pc", o_pc, m_pc);
        chk("m_imm", o_imm, m_imm);
        chk("m_alu_op", 32'(o_alu_op), 32'(m_op));
        chk("m_sels", 32'({o_op_a_sel, o_op_b_sel}), 32'({m_asel, m_bsel}));
        chk("m_rd", 32'(o_ex_rd_addr), 32'(m_rd));
        chk("m_is_load", 32'(o_ex_is_load), 32'(m_load));
        chk("m_br_less", 32'(o_br_less), 32'(el));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] rs1a, input logic [31:0] rs1d,
                        input logic [4:0] rs2a, input logic [31:0] rs2d,
                        input logic [4:0] rd, input logic asel, input logic bsel,
                        input logic [3:0] op, input logic uns, input logic wren,
                        input logic load);
    id_valid = 1'b1; id_pc = pc; id_imm = imm; id_rs1a = rs1a; id_rs1d = rs1d;
    id_rs2a = rs2a; id_rs2d = rs2d; id_rd = rd; id_asel = asel; id_bsel = bsel;
    id_op = op; id_uns = uns; id_wren = wren; id_load = load;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    set_id(32'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
    mem_a = 5'd0; mem_w = 1'b0; mem_d = 32'd0; wb_a = 5'd0; wb_w = 1'b0; wb_d = 32'd0;
    tick();
    cmp_on = 1'b1;
    tick();
    chk("rst_ready", 32'(o_id_ready), 32'd0);
    chk("rst_valid", 32'(o_ex_valid), 32'd0);
    chk("rst_alu_op", 32'(o_alu_op), 32'd0);
    rst = 1'b0;

    // Plain issue: add x3, x1(5), x2(7).
    set_id(32'h10, 32'd0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    tick(); id_valid = 1'b0; #1;
    chk("plain_a", o_operand_a, 32'd5);
    chk("plain_b", o_operand_b, 32'd7);
    chk("plain_op", 32'(o_alu_op), 32'd0);
    chk("plain_valid", 32'(o_ex_valid), 32'd1);

    // Forward priority on rs1=x3.
    set_id(32'h14, 32'd0, 5'd3, 32'h11, 5'd0, 32'd0, 5'd4, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    tick(); id_valid = 1'b0;
    mem_a = 5'd3; mem_w = 1'b1; mem_d = 32'hAA; wb_a = 5'd3; wb_w = 1'b1; wb_d = 32'hBB; #1;
    chk("fwd_mem", o_operand_a, 32'hAA);
    mem_w = 1'b0; #1;
    chk("fwd_wb", o_operand_a, 32'hBB);
    wb_w = 1'b0;
    set_id(32'h18, 32'd0, 5'd0, 32'h77, 5'd0, 32'd0, 5'd4, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    mem_a = 5'd0; mem_w = 1'b1; mem_d = 32'hAA;
    tick(); id_valid = 1'b0; #1;
    chk("fwd_x0", o_operand_a, 32'd0);
    mem_w = 1'b0;

    // Load-use: lw x5 then add x6, x5, x1.
    set_id(32'h20, 32'd0, 5'd1, 32'd0, 5'd0, 32'd0, 5'd5, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(32'h24, 32'd0, 5'd5, 32'hDEAD, 5'd1, 32'd3, 5'd6, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    #1 chk("lu_ready", 32'(o_id_ready), 32'd0);
    tick();
    chk("lu_bubble", 32'(o_ex_valid), 32'd0);
    chk("lu_ready_after", 32'(o_id_ready), 32'd1);
    tick(); id_valid = 1'b0;
    wb_a = 5'd5; wb_w = 1'b1; wb_d = 32'h1234; #1;
    chk("lu_fwd", o_operand_a, 32'h1234);
    chk("lu_rd", 32'(o_ex_rd_addr), 32'd6);
    wb_w = 1'b0;

    // Back-to-back load-use: lw x7; lw x8,(x7); add x9,x8.
    set_id(32'h30, 32'd0, 5'd1, 32'd0, 5'd0, 32'd0, 5'd7, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(32'h34, 32'd0, 5'd7, 32'd0, 5'd0, 32'd0, 5'd8, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    #1 chk("b2b_ready1", 32'(o_id_ready), 32'd0);
    tick(); tick();
    set_id(32'h38, 32'd0, 5'd8, 32'd0, 5'd0, 32'd0, 5'd9, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    #1 chk("b2b_ready2", 32'(o_id_ready), 32'd0);
    tick(); tick(); id_valid = 1'b0; #1;
    chk("b2b_rd", 32'(o_ex_rd_addr), 32'd9);

    // Stall refresh: WB x2 retires during the first stalled cycle only.
    set_id(32'h40, 32'd0, 5'd1, 32'd1, 5'd2, 32'h10, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(32'h44, 32'd0, 5'd4, 32'd0, 5'd0, 32'd0, 5'd4, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    stall = 1'b1; wb_a = 5'd2; wb_w = 1'b1; wb_d = 32'h55;
    #1 chk("stall_ready1", 32'(o_id_ready), 32'd0);
    tick(); wb_w = 1'b0;
    #1 chk("stall_ready2", 32'(o_id_ready), 32'd0);
    tick();
    chk("stall_ready3", 32'(o_id_ready), 32'd0);
    tick(); stall = 1'b0; #1;
    chk("stall_b", o_operand_b, 32'h55);
    chk("stall_rd", 32'(o_ex_rd_addr), 32'd3);
    tick(); id_valid = 1'b0;

    // Flush beats stall.
    set_id(32'h50, 32'd0, 5'd1, 32'd1, 5'd0, 32'd0, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    tick(); flush = 1'b1; stall = 1'b1;
    tick(); flush = 1'b0; stall = 1'b0; id_valid = 1'b0; #1;
    chk("flush_valid", 32'(o_ex_valid), 32'd0);

    // Reset while sitting in a load-use bubble.
    set_id(32'h60, 32'h8, 5'd1, 32'd0, 5'd0, 32'd0, 5'd5, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(32'h64, 32'd0, 5'd5, 32'd0, 5'd1, 32'd0, 5'd6, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    tick(); rst = 1'b1; #1;
    chk("rstb_pc", o_pc, 32'd0);
    chk("rstb_imm", o_imm, 32'd0);
    chk("rstb_ready", 32'(o_id_ready), 32'd0);
    chk("rstb_valid", 32'(o_ex_valid), 32'd0);
    tick(); rst = 1'b0;
    tick(); id_valid = 1'b0; #1;
    chk("rstb_issue", 32'(o_ex_valid), 32'd1);
    chk("rstb_issue_rd", 32'(o_ex_rd_addr), 32'd6);

    // br_less cases.
    set_id(32'h70, 32'd0, 5'd1, 32'hFFFFFFFF, 5'd2, 32'd1, 5'd3, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(32'h74, 32'd0, 5'd1, 32'hFFFFFFFF, 5'd2, 32'd1, 5'd3, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0);
    #1 chk("brl_signed", 32'(o_br_less), 32'd1);
    tick();
    set_id(32'h78, 32'd0, 5'd1, 32'hFFFFFFFD, 5'd2, 32'd5, 5'd3, 1'b0, 1'b1, 4'b0101, 1'b0, 1'b1, 1'b0);
    #1 chk("brl_unsigned", 32'(o_br_less), 32'd0);
    tick();
    set_id(32'h100, 32'h80, 5'd1, 32'd0, 5'd2, 32'hFFFF, 5'd3, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
    #1 chk("brl_slti", 32'(o_br_less), 32'd1);
    tick(); id_valid = 1'b0; #1;
    chk("brl_pc_imm", 32'(o_br_less), 32'd0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
